soundrive_dac: RTL

//  4-channel 8-bit Soundrive/Covox DAC plus ZX beeper mixer with a 1-bit first-order delta-sigma output.

---
 rtl/soundrive_dac_pkg.sv | 24 ++
 rtl/soundrive_dac_if.sv | 21 ++
 rtl/soundrive_dac_sd_mod1.sv | 34 +++
 rtl/soundrive_dac.sv | 108 ++++++++++
 4 files changed

// File: rtl/soundrive_dac_pkg.sv
// Shared definitions for the Soundrive/Covox DAC and any future DAC/AY mixer:
// datapath widths, channel reset default and dither LFSR seed/taps.
package soundrive_dac_pkg;

    localparam int unsigned SD_ACC_W    = 12;
    localparam int unsigned SD_MIX_W    = 11;
    localparam int unsigned SD_CH_W     = 8;
    localparam int unsigned SD_NCH      = 4;
    localparam int unsigned SD_DITHER_W = 2;
    localparam int unsigned SD_CNT_W    = 8;

    localparam logic [SD_CH_W-1:0] SD_CH_RST    = 8'h80;
    localparam logic [15:0]        SD_LFSR_SEED = 16'hACE1;

    typedef logic [SD_MIX_W-1:0]    sd_mix_t;
    typedef logic [SD_CH_W-1:0]     sd_ch_t;
    typedef logic [SD_DITHER_W-1:0] sd_dither_t;

    // Fibonacci LFSR step, taps 16,14,13,11 (bits 15,13,12,10), shifting towards the MSB.
    function automatic logic [15:0] sd_lfsr_next(input logic [15:0] s);
        return {s[14:0], s[15] ^ s[13] ^ s[12] ^ s[10]};
    endfunction

endpackage

// File: rtl/soundrive_dac_if.sv
// Port-write bus from the Z80 port decoder into the Soundrive DAC.
// The decoder drives the master side; the DAC consumes the slave side.
interface soundrive_dac_if;

    logic       wr_stb;
    logic [1:0] wr_chan;
    logic [7:0] wr_data;

    modport master (
        output wr_stb,
        output wr_chan,
        output wr_data
    );

    modport slave (
        input wr_stb,
        input wr_chan,
        input wr_data
    );

endinterface

// File: rtl/soundrive_dac_sd_mod1.sv
// sd_mod1: tick-enabled first-order delta-sigma modulator.
// Integrates mix + dither on each enabled cycle; the carry out is the output bit.
module sd_mod1
    import soundrive_dac_pkg::*;
(
    input  logic       fclk,
    input  logic       rst,
    input  logic       en,
    input  sd_mix_t    mix,
    input  sd_dither_t dither,
    output logic       bitstream
);

    // Bit 11 of the 12-bit accumulator is never fed back, so it lives only in bitstream.
    logic [SD_ACC_W-2:0] acc;
    logic [SD_ACC_W-1:0] sum;

    // Next accumulator value: lower 11 bits of acc plus the current mix and dither.
    always_comb begin
        sum = {1'b0, acc} + {1'b0, mix} + {{(SD_ACC_W-SD_DITHER_W){1'b0}}, dither};
    end

    // Integrate on tick cycles only; acc and output hold in between.
    always_ff @(posedge fclk) begin
        if (rst) begin
            acc       <= '0;
            bitstream <= 1'b0;
        end else if (en) begin
            acc       <= sum[SD_ACC_W-2:0];
            bitstream <= sum[SD_ACC_W-1];
        end
    end

endmodule

// File: rtl/soundrive_dac.sv
// soundrive_dac: 4-channel 8-bit Soundrive/Covox DAC plus ZX beeper mixer
// driving a 1-bit first-order delta-sigma output on the beep pin.
// Optional feature macro: SOUNDRIVE_DITHER_EN (adds 2-bit LFSR dither per tick).
module soundrive_dac
    import soundrive_dac_pkg::*;
#(
    parameter int unsigned RATE_DIV = 8,
    parameter int unsigned BEEP_LVL = 255,
    parameter logic [7:0]  CH_RST   = SD_CH_RST
)(
    input  logic                fclk,
    input  logic                rst,
    soundrive_dac_if.slave      wr,
    input  logic                beep_in,
    output logic                beep,
    output logic [SD_MIX_W-1:0] mix_out
);

    localparam sd_mix_t             BEEP_MIX  = sd_mix_t'(BEEP_LVL);
    localparam logic [SD_CNT_W-1:0] TICK_LAST = SD_CNT_W'(RATE_DIV - 1);

    sd_ch_t              ch [SD_NCH];
    logic [SD_CH_W:0]    s01;
    logic [SD_CH_W:0]    s23;
    logic                beep_q;
    logic [SD_CNT_W-1:0] tick_cnt;
    logic                tick;
    sd_dither_t          dither;

    // Channel registers: every strobe is captured, later writes overwrite earlier ones.
    always_ff @(posedge fclk) begin
        if (rst) begin
            for (int unsigned i = 0; i < SD_NCH; i++) begin
                ch[i] <= CH_RST;
            end
        end else if (wr.wr_stb) begin
            ch[wr.wr_chan] <= wr.wr_data;
        end
    end

    // Mix stage 1: pairwise channel sums and beeper bit capture.
    always_ff @(posedge fclk) begin
        if (rst) begin
            s01    <= '0;
            s23    <= '0;
            beep_q <= 1'b0;
        end else begin
            s01    <= {1'b0, ch[0]} + {1'b0, ch[1]};
            s23    <= {1'b0, ch[2]} + {1'b0, ch[3]};
            beep_q <= beep_in;
        end
    end

    // Mix stage 2: final 11-bit mix word, sized so it can never overflow.
    always_ff @(posedge fclk) begin
        if (rst) begin
            mix_out <= '0;
        end else begin
            mix_out <= sd_mix_t'(s01) + sd_mix_t'(s23) + (beep_q ? BEEP_MIX : '0);
        end
    end

    // Tick generator: counts 0..RATE_DIV-1, tick asserted on the last count.
    always_ff @(posedge fclk) begin
        if (rst) begin
            tick_cnt <= '0;
        end else if (tick) begin
            tick_cnt <= '0;
        end else begin
            tick_cnt <= tick_cnt + 1'b1;
        end
    end

    always_comb begin
        tick = (tick_cnt == TICK_LAST);
    end

`ifdef SOUNDRIVE_DITHER_EN
    logic [15:0] lfsr;

    // Dither LFSR advances once per modulator tick.
    always_ff @(posedge fclk) begin
        if (rst) begin
            lfsr <= SD_LFSR_SEED;
        end else if (tick) begin
            lfsr <= sd_lfsr_next(lfsr);
        end
    end

    always_comb begin
        dither = lfsr[SD_DITHER_W-1:0];
    end
`else
    always_comb begin
        dither = '0;
    end
`endif

    sd_mod1 u_mod (
        .fclk      (fclk),
        .rst       (rst),
        .en        (tick),
        .mix       (mix_out),
        .dither    (dither),
        .bitstream (beep)
    );

endmodule
